seg_scan_driver: RTL

Parametrised multi-digit, time-multiplexed driver for common-anode seven-segment displays. It latches a packed bank of hex digit codes and scans them onto one shared active-low segment bus, one digit per refresh slot, with a one-cycle dead time between digits. It decodes hex 0-F, adds per-digit decimal points, per-digit blanking and optional leading-zero suppression. It sits between the datapath (counters, register views) and the board's anode/segment pins.

---
 rtl/seg_scan_driver.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: shadowed hex digits, dp,
// blanking and leading-zero suppression scanned onto one active-low segment bus.
module seg_scan_driver #(
    parameter int DIGITS = 8,
    parameter int DIV    = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;
    logic                sh_lz;

    logic [DIGITS-1:0]   supp;
    logic                zero_run;
    logic [3:0]          cur_code;
    logic                cur_dp;
    logic                cur_blank;
    logic                cur_supp;
    logic [DIGITS-1:0]   an_nxt;
    logic [7:0]          seg_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] code);
        case (code)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0011000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // A digit is suppressed while it and every more significant digit are zero.
    always_comb begin
        supp     = '0;
        zero_run = sh_lz;
        for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
            zero_run             = zero_run & (sh_data[4*(DIGITS-1-k) +: 4] == 4'h0);
            supp[DIGITS-1-k]     = zero_run;
        end
    end

    always_comb begin
        cur_code  = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_supp  = 1'b0;
        an_nxt    = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_code  = sh_data[4*i +: 4];
                cur_dp    = sh_dp[i];
                cur_blank = sh_blank[i];
                cur_supp  = supp[i];
                an_nxt[i] = 1'b0;
            end
        end
        // Segments are dark during the dead cycle too, so no ghosting on the anode switch.
        if (div_cnt == '0) begin
            an_nxt  = '1;
            seg_nxt = 8'hFF;
        end else if (cur_blank) begin
            seg_nxt = 8'hFF;
        end else if (cur_supp) begin
            seg_nxt = {~cur_dp, 7'h7F};
        end else begin
            seg_nxt = {~cur_dp, hex7(cur_code)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            idx      <= '0;
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_lz    <= 1'b0;
            an       <= '1;
            seg      <= 8'hFF;
        end else begin
            if (load) begin
                sh_data  <= data;
                sh_dp    <= dp;
                sh_blank <= blank;
                sh_lz    <= lz_en;
            end
            an  <= an_nxt;
            seg <= seg_nxt;
            if (div_cnt == CNT_MAX) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule
